// File: rtl/dataram_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between the core (port 0)
// and the loader/debug port (port 1), with a port 1 bus lock and read-return tracking.
module dataram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              CLOCK,
    input  logic              RST,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    input  logic              p1_lock,
    output logic              ram_ena_rd,
    output logic              ram_ena_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              locked
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t     state;
    logic       last_gnt;
    logic [1:0] pipe [RD_LAT];
    logic [1:0] tail;
    logic       gnt0;
    logic       gnt1;

    // Dropping p1_lock releases the bus in the same cycle, so the lock only
    // blocks port 0 while it is still held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (RST) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else if (state == LOCKED && p1_lock) begin
            gnt1 = p1_req;
        end else if (p0_req && p1_req) begin
            gnt0 = last_gnt;
            gnt1 = ~last_gnt;
        end else begin
            gnt0 = p0_req;
            gnt1 = p1_req;
        end
    end

    assign p0_gnt     = gnt0;
    assign p1_gnt     = gnt1;
    assign ram_ena_wr = (gnt0 & p0_we) | (gnt1 & p1_we);
    assign ram_ena_rd = (gnt0 & ~p0_we) | (gnt1 & ~p1_we);
    assign ram_addr   = gnt0 ? p0_addr  : (gnt1 ? p1_addr  : '0);
    assign ram_wdata  = gnt0 ? p0_wdata : (gnt1 ? p1_wdata : '0);

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe[i] <= 2'b00;
            end
        end else begin
            case (state)
                IDLE:    if (gnt1 && p1_lock) state <= LOCKED;
                LOCKED:  if (!p1_lock) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (gnt0 || gnt1) begin
                last_gnt <= gnt1;
            end
            // Each slot carries {read issued, issuing port} toward the RAM output.
            pipe[0] <= {ram_ena_rd, gnt1};
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign tail      = pipe[RD_LAT-1];
    assign p0_rvalid = ~RST & tail[1] & ~tail[0];
    assign p1_rvalid = ~RST & tail[1] & tail[0];
    assign p0_rdata  = ram_rdata;
    assign p1_rdata  = ram_rdata;
    assign locked    = ~RST & (state == LOCKED);

endmodule
